// File: rtl/perf_pkg.sv
// perf_pkg: shared defaults and saturation mode constants for the performance counter bank
package perf_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_NUM_CH = 4;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
endpackage

// File: rtl/perf_counter.sv
// perf_counter: one event counter (clk, rst, inc, clr -> value, sticky ovf) that wraps or saturates at all-ones
module perf_counter
  import perf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             ovf
);
  logic full;
  assign full = &value;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      value <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      value <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      value <= (full && SATURATE == MODE_SAT) ? value : value + 1'b1;
      ovf <= ovf | full;
    end
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CH event counters plus a cycle counter (clk, rst, en, clr, evt, snap, sel -> cycle, rd_data, ovf, snap_valid) with snapshot shadows
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SATURATE = MODE_WRAP,
  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [NUM_CH-1:0] evt,
  input  logic              snap,
  input  logic [SW-1:0]     sel,
  output logic [WIDTH-1:0]  cycle,
  output logic [WIDTH-1:0]  rd_data,
  output logic [NUM_CH:0]   ovf,
  output logic              snap_valid
);
  logic [WIDTH-1:0] live [NUM_CH+1];
  logic [WIDTH-1:0] shadow [NUM_CH];
  logic [NUM_CH:0] inc;
  assign inc = {1'b1, evt} & {(NUM_CH+1){en}};
  assign cycle = live[NUM_CH];
  for (genvar g = 0; g <= NUM_CH; g++) begin : g_cnt
    perf_counter #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_cnt (
      .clk(clk),
      .rst(rst),
      .inc(inc[g]),
      .clr(clr),
      .value(live[g]),
      .ovf(ovf[g])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      rd_data <= '0;
      snap_valid <= 1'b0;
    end else begin
      if (snap) for (int i = 0; i < NUM_CH; i++) shadow[i] <= live[i];
      snap_valid <= snap;
      rd_data <= (int'(sel) < NUM_CH) ? shadow[sel] : '0;
    end
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: event-count reference model plus directed vectors for three bank configurations
module tb_perf_counter_bank;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0, snap = 1'b0;
  logic [4:0] evt = '0;
  logic [2:0] sel = '0;
  logic [31:0] cyc_a, rd_a;
  logic [4:0] ovf_a;
  logic [7:0] cyc_b, rd_b, cyc_c, rd_c;
  logic [5:0] ovf_b, ovf_c;
  logic sv_a, sv_b, sv_c;
  int errors = 0, checks = 0;
  longint cyc_n;
  longint ch_n [5];
  longint sh_n [5];
  logic sv_e;
  logic [63:0] rda, rdb, rdc;
  always #5 clk = ~clk;
  perf_counter_bank #(.WIDTH(32), .NUM_CH(4), .SATURATE(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .evt(evt[3:0]), .snap(snap), .sel(sel[1:0]),
    .cycle(cyc_a), .rd_data(rd_a), .ovf(ovf_a), .snap_valid(sv_a)
  );
  perf_counter_bank #(.WIDTH(8), .NUM_CH(5), .SATURATE(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .evt(evt), .snap(snap), .sel(sel),
    .cycle(cyc_b), .rd_data(rd_b), .ovf(ovf_b), .snap_valid(sv_b)
  );
  perf_counter_bank #(.WIDTH(8), .NUM_CH(5), .SATURATE(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .evt(evt), .snap(snap), .sel(sel),
    .cycle(cyc_c), .rd_data(rd_c), .ovf(ovf_c), .snap_valid(sv_c)
  );
  function automatic logic [63:0] fv(input longint n, input int w, input bit s);
    longint m = (longint'(1) << w) - 1;
    return s ? ((n > m) ? m : n) : (n & m);
  endfunction
  function automatic logic fo(input longint n, input int w);
    return n > ((longint'(1) << w) - 1);
  endfunction
  function automatic logic [63:0] ovv(input int w, input int nch);
    logic [63:0] r = '0;
    for (int i = 0; i < nch; i++) r[i] = fo(ch_n[i], w);
    r[nch] = fo(cyc_n, w);
    return r;
  endfunction
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  always @(posedge clk or posedge rst)
    if (rst) begin
      cyc_n <= 0;
      ch_n <= '{default: 0};
      sh_n <= '{default: 0};
      sv_e <= 1'b0;
      rda <= '0;
      rdb <= '0;
      rdc <= '0;
    end else begin
      if (clr) begin
        cyc_n <= 0;
        ch_n <= '{default: 0};
      end else if (en) begin
        cyc_n <= cyc_n + 1;
        for (int i = 0; i < 5; i++) ch_n[i] <= ch_n[i] + longint'(evt[i]);
      end
      if (snap) sh_n <= ch_n;
      sv_e <= snap;
      rda <= fv(sh_n[sel[1:0]], 32, 1'b0);
      rdb <= (sel < 3'd5) ? fv(sh_n[sel], 8, 1'b0) : '0;
      rdc <= (sel < 3'd5) ? fv(sh_n[sel], 8, 1'b1) : '0;
    end
  always @(negedge clk) begin
    check("cycle_a", 64'(cyc_a), fv(cyc_n, 32, 1'b0));
    check("cycle_b", 64'(cyc_b), fv(cyc_n, 8, 1'b0));
    check("cycle_c", 64'(cyc_c), fv(cyc_n, 8, 1'b1));
    check("ovf_a", 64'(ovf_a), ovv(32, 4));
    check("ovf_b", 64'(ovf_b), ovv(8, 5));
    check("ovf_c", 64'(ovf_c), ovv(8, 5));
    check("rd_a", 64'(rd_a), rda);
    check("rd_b", 64'(rd_b), rdb);
    check("rd_c", 64'(rd_c), rdc);
    check("snap_valid_a", 64'(sv_a), 64'(sv_e));
    check("snap_valid_b", 64'(sv_b), 64'(sv_e));
    check("snap_valid_c", 64'(sv_c), 64'(sv_e));
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    en = 1'b1;
    evt = 5'b00101;
    repeat (10) step();
    en = 1'b0;
    evt = '0;
    snap = 1'b1;
    step();
    snap = 1'b0;
    check("lit_cycle10", 64'(cyc_a), 64'd10);
    check("lit_snap_valid", 64'(sv_a), 64'd1);
    for (int s = 0; s < 4; s++) begin
      sel = 3'(s);
      step();
      check("lit_rd_ch", 64'(rd_a), (s % 2 == 0) ? 64'd10 : 64'd0);
    end
    check("lit_snap_valid_drop", 64'(sv_a), 64'd0);
    sel = 3'd5;
    step();
    check("lit_sel_oob_b", 64'(rd_b), 64'd0);
    check("lit_sel_oob_c", 64'(rd_c), 64'd0);
    sel = 3'd2;
    step();
    check("lit_sel2_b", 64'(rd_b), 64'd10);
    evt = 5'b11111;
    repeat (20) step();
    check("lit_en0_cycle", 64'(cyc_a), 64'd10);
    evt = '0;
    snap = 1'b1;
    step();
    snap = 1'b0;
    sel = 3'd1;
    step();
    check("lit_en0_ch1", 64'(rd_a), 64'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    en = 1'b1;
    evt = 5'b00001;
    repeat (7) step();
    clr = 1'b1;
    snap = 1'b1;
    step();
    clr = 1'b0;
    snap = 1'b0;
    en = 1'b0;
    evt = '0;
    check("lit_clr_cycle", 64'(cyc_a), 64'd0);
    check("lit_clr_ovf", 64'(ovf_a), 64'd0);
    check("lit_clr_snap_valid", 64'(sv_a), 64'd1);
    sel = 3'd0;
    step();
    check("lit_clr_shadow", 64'(rd_a), 64'd7);
    check("lit_clr_snap_valid_drop", 64'(sv_a), 64'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    en = 1'b1;
    evt = 5'b10001;
    repeat (257) step();
    en = 1'b0;
    evt = '0;
    check("lit_wrap_cycle", 64'(cyc_b), 64'd1);
    check("lit_sat_cycle", 64'(cyc_c), 64'd255);
    check("lit_wrap_ovf", 64'(ovf_b), 64'b110001);
    check("lit_sat_ovf", 64'(ovf_c), 64'b110001);
    check("lit_wide_cycle", 64'(cyc_a), 64'd257);
    snap = 1'b1;
    step();
    snap = 1'b0;
    sel = 3'd4;
    step();
    check("lit_wrap_ch4", 64'(rd_b), 64'd1);
    check("lit_sat_ch4", 64'(rd_c), 64'd255);
    sel = 3'd0;
    step();
    check("lit_wide_ch0", 64'(rd_a), 64'd257);
    en = 1'b1;
    evt = 5'b11111;
    repeat (3) step();
    snap = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("lit_async_cycle_a", 64'(cyc_a), 64'd0);
    check("lit_async_cycle_c", 64'(cyc_c), 64'd0);
    check("lit_async_ovf_b", 64'(ovf_b), 64'd0);
    check("lit_async_rd_a", 64'(rd_a), 64'd0);
    check("lit_async_sv_a", 64'(sv_a), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    snap = 1'b0;
    step();
    check("lit_post_rst_cycle", 64'(cyc_a), 64'd1);
    check("lit_post_rst_sv", 64'(sv_a), 64'd0);
    en = 1'b0;
    snap = 1'b1;
    step();
    snap = 1'b0;
    sel = 3'd3;
    step();
    check("lit_post_rst_ch3", 64'(rd_a), 64'd1);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
